serial_subtractor_16b: RTL and testbench
========================================

SERIAL_SUBTRACTOR_16B -- requirements
Module: serial_subtractor_16b

Interface
REQ-001 SHALL have no parameters; the operand width is fixed at 16 bits.
REQ-002 SHALL provide port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL provide port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port: start  input  1  request to begin a subtraction, sampled on rising clk.
REQ-005 SHALL provide port: a  input  16  minuend, sampled only when start is accepted.
REQ-006 SHALL provide port: b  input  16  subtrahend, sampled only when start is accepted.
REQ-007 SHALL provide port: bin  input  1  borrow-in, sampled only when start is accepted.
REQ-008 SHALL provide port: diff  output  16  registered result a - b - bin, modulo 2^16.
REQ-009 SHALL provide port: bout  output  1  registered borrow-out (1 when a < b + bin, unsigned).
REQ-010 SHALL provide port: busy  output  1  high while a subtraction is in progress.
REQ-011 SHALL provide port: done  output  1  single-cycle pulse, result valid.

Function
REQ-012 SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-013 IDLE: start=1 at a rising edge SHALL latch a, b, bin into internal registers, clear the 4-bit bit counter to 0, and enter RUN.
REQ-014 IDLE: start=0 SHALL remain in IDLE with all outputs holding.
REQ-015 RUN: each rising edge SHALL compute one bit, LSB first, using a full subtractor on (a[k], b[k], running borrow), where k = bit counter.
REQ-016 Full-subtractor rule: d = x^y^br; next borrow = (~x & y) | (~(x^y) & br); the running borrow starts at the latched bin.
REQ-017 RUN: the bit counter SHALL increment by 1 per edge; at the edge processing k=15, the FSM SHALL enter DONE and load diff and bout from the completed result in that same edge.
REQ-018 Latency: if start is accepted at edge N, diff/bout SHALL be updated at edge N+16 and done SHALL be high for the cycle between edges N+16 and N+17.
REQ-019 DONE: the next rising edge SHALL unconditionally return to IDLE and deassert done.
REQ-020 busy SHALL be 1 exactly while the state is RUN; done SHALL be 1 exactly while the state is DONE; both are registered-state decodes.
REQ-021 start SHALL be ignored in RUN and DONE; the operands in flight SHALL not change and no restart SHALL occur.
REQ-022 Back-to-back operation: start held high continuously SHALL be accepted at the first IDLE edge following DONE, giving one new result every 18 cycles.
REQ-023 diff and bout SHALL hold their last value from the completion edge until the next completion edge; they SHALL NOT change during RUN.
REQ-024 Changes on a, b, bin outside the accepting edge SHALL have no effect on the result.

Reset
REQ-025 rst_n=0 SHALL immediately, regardless of clk, force: state IDLE, bit counter 0, internal operand/borrow registers 0, diff=16'h0000, bout=0, busy=0, done=0.
REQ-026 Reset asserted mid-operation (RUN or DONE) SHALL abort the operation, with no done pulse produced for that operation.
REQ-027 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-028 Basic subtraction: a=16'h1234, b=16'h0234, bin=0, start pulse -> after 16 edges, done=1 for one cycle, diff=16'h1000, bout=0.
REQ-029 Underflow: a=16'h0000, b=16'h0001, bin=0 -> diff=16'hFFFF, bout=1; and a=16'h8000, b=16'h8000, bin=1 -> diff=16'hFFFF, bout=1.
REQ-030 Busy lockout: start a=16'h00FF, b=16'h000F, bin=0, then pulse start with a=16'hFFFF, b=16'h0000 at the 5th RUN cycle -> exactly one done pulse, diff=16'h00F0, bout=0, busy high for exactly 16 cycles.
REQ-031 Reset mid-run: rst_n low during the 8th RUN cycle -> all outputs 0 within that same cycle, no done pulse, and a later start with a=16'h0005, b=16'h0003 -> diff=16'h0002, bout=0.
REQ-032 Back-to-back: start held high across two operations (16'hFFFF-16'h0001, then 16'h0001-16'h0002) -> done pulses 18 cycles apart with results 16'hFFFE/bout=0, then 16'hFFFF/bout=1.
REQ-033 Randomized check: at least 1000 random a, b, bin -> every {bout, diff} SHALL equal the 17-bit reference ({1'b0,a} - {1'b0,b} - bin).

Source files
------------

// File: rtl/serial_subtractor_16b_if.sv
// Request/result signal bundle for the bit-serial 16-bit subtractor.
interface serial_subtractor_16b_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic [15:0] diff;
  logic        bout;
  logic        busy;
  logic        done;

  modport master (
    output start, a, b, bin,
    input  diff, bout, busy, done
  );

  modport slave (
    input  start, a, b, bin,
    output diff, bout, busy, done
  );
endinterface

// File: rtl/serial_subtractor_16b.sv
// Bit-serial 16-bit subtractor: one full-subtractor step per clock, LSB first.
// diff/bout are loaded only on the completion edge and hold until the next one.
module serial_subtractor_16b (
  input  logic                    clk,
  input  logic                    rst_n,
  serial_subtractor_16b_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic        br_q, br_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] diff_q, diff_d;
  logic        bout_q, bout_d;

  logic        x, y, dbit, nbr;

  // Current operand bits; operands shift right so bit k is always at position 0.
  always_comb begin
    x    = a_q[0];
    y    = b_q[0];
    dbit = x ^ y ^ br_q;
    nbr  = (~x & y) | (~(x ^ y) & br_q);
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      br_q    <= 1'b0;
      acc_q   <= 16'h0000;
      diff_q  <= 16'h0000;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      acc_q   <= acc_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    acc_d   = acc_q;
    diff_d  = diff_q;
    bout_d  = bout_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          br_d    = bus.bin;
          cnt_d   = 4'd0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d   = {1'b0, a_q[15:1]};
        b_d   = {1'b0, b_q[15:1]};
        br_d  = nbr;
        // Result bits enter at the top; after 16 steps bit 0 sits at position 0.
        acc_d = {dbit, acc_q[15:1]};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          diff_d  = {dbit, acc_q[15:1]};
          bout_d  = nbr;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decodes of registered state.
  always_comb begin
    bus.diff = diff_q;
    bus.bout = bout_q;
    bus.busy = (state_q == StRun);
    bus.done = (state_q == StDone);
  end

endmodule

// File: tb/tb_serial_subtractor_16b.sv
// Scoreboard bench for serial_subtractor_16b: stimulus pushes expected {bout, diff},
// a monitor pops and compares on every done pulse.
module tb_serial_subtractor_16b;

  logic clk;
  logic rst_n;

  serial_subtractor_16b_if bus ();

  serial_subtractor_16b dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          failures;
  int          done_count;
  int          cyc;
  int          last_done_cyc;
  int          prev_done_cyc;
  logic        prev_done;
  logic [16:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor: compare each presented result against the oldest expectation.
  initial begin
    logic [16:0] e;
    done_count    = 0;
    last_done_cyc = 0;
    prev_done_cyc = 0;
    prev_done     = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.done) begin
        done_count++;
        prev_done_cyc = last_done_cyc;
        last_done_cyc = cyc;
        check("done_single_cycle", {31'd0, prev_done}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: actual=%0h required=none", {bus.bout, bus.diff});
        end else begin
          e = exp_q.pop_front();
          check("result", {15'd0, bus.bout, bus.diff}, {15'd0, e});
        end
      end
      prev_done = rst_n & bus.done;
    end
  end

  // One operation; inject>0 pulses a conflicting start on that RUN cycle.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                       input logic [16:0] expv, input int inject);
    int   n;
    int   busy_n;
    logic got;
    logic stable;
    logic [15:0] hold;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    exp_q.push_back(expv);
    hold   = bus.diff;
    n      = 0;
    busy_n = 0;
    got    = 1'b0;
    stable = 1'b1;
    while (n < 40 && !got) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        bus.start = 1'b0;
        bus.a     = 16'($urandom);
        bus.b     = 16'($urandom);
        bus.bin   = 1'($urandom);
      end
      if (inject != 0 && n == inject) begin
        bus.start = 1'b1;
        bus.a     = 16'hFFFF;
        bus.b     = 16'h0000;
        bus.bin   = 1'b0;
      end
      if (inject != 0 && n == inject + 1) bus.start = 1'b0;
      if (bus.busy) begin
        busy_n++;
        if (bus.diff !== hold) stable = 1'b0;
      end
      if (bus.done) got = 1'b1;
    end
    check("latency", n, 32'd17);
    check("busy_cycles", busy_n, 32'd16);
    check("diff_stable_in_run", {31'd0, stable}, 32'd1);
  endtask

  initial begin
    int dc;
    int n;
    logic [15:0] ra, rb;
    logic        rbin;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = 16'h0;
    bus.b     = 16'h0;
    bus.bin   = 1'b0;
    #1;
    check("reset_diff", {16'd0, bus.diff}, 32'h0);
    check("reset_bout", {31'd0, bus.bout}, 32'd0);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    do_op(16'h1234, 16'h0234, 1'b0, {1'b0, 16'h1000}, 0);
    do_op(16'h0000, 16'h0001, 1'b0, {1'b1, 16'hFFFF}, 0);
    do_op(16'h8000, 16'h8000, 1'b1, {1'b1, 16'hFFFF}, 0);
    do_op(16'hABCD, 16'hABCD, 1'b0, {1'b0, 16'h0000}, 0);
    do_op(16'h0000, 16'hFFFF, 1'b1, {1'b1, 16'h0000}, 0);

    // Busy lockout: start pulsed on the 5th RUN cycle must be ignored
    dc = done_count;
    do_op(16'h00FF, 16'h000F, 1'b0, {1'b0, 16'h00F0}, 5);
    repeat (30) @(negedge clk);
    check("lockout_done_count", done_count - dc, 32'd1);
    check("lockout_idle_busy", {31'd0, bus.busy}, 32'd0);

    // Reset during the 8th RUN cycle
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'h1234;
    bus.b     = 16'h0001;
    bus.bin   = 1'b0;
    n = 0;
    while (n < 8) begin
      @(negedge clk);
      n++;
      bus.start = 1'b0;
    end
    check("pre_reset_busy", {31'd0, bus.busy}, 32'd1);
    dc = done_count;
    rst_n = 1'b0;
    #1;
    check("midrun_reset_diff", {16'd0, bus.diff}, 32'h0);
    check("midrun_reset_bout", {31'd0, bus.bout}, 32'd0);
    check("midrun_reset_busy", {31'd0, bus.busy}, 32'd0);
    check("midrun_reset_done", {31'd0, bus.done}, 32'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("no_done_after_abort", done_count - dc, 32'd0);
    do_op(16'h0005, 16'h0003, 1'b0, {1'b0, 16'h0002}, 0);

    // Back-to-back with start held high
    dc = done_count;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'hFFFF;
    bus.b     = 16'h0001;
    bus.bin   = 1'b0;
    exp_q.push_back({1'b0, 16'hFFFE});
    @(negedge clk);
    bus.a = 16'h0001;
    bus.b = 16'h0002;
    exp_q.push_back({1'b1, 16'hFFFF});
    n = 0;
    while (n < 60 && done_count < dc + 2) begin
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    check("b2b_done_count", done_count - dc, 32'd2);
    check("b2b_spacing", last_done_cyc - prev_done_cyc, 32'd18);
    repeat (25) @(negedge clk);
    check("b2b_no_third_op", done_count - dc, 32'd2);

    // Randomized operands against the 17-bit reference
    for (int i = 0; i < 1000; i++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom);
      do_op(ra, rb, rbin, {1'b0, ra} - {1'b0, rb} - {16'd0, rbin}, 0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
